// File: rtl/trace_capture_pkg.sv
// Shared definitions for the trace capture block and its host-side checker.
package trace_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN
  } state_e;

  // A stored sample is the concatenation {y, x}.
  function automatic int sample_w(input int width);
    return 2 * width;
  endfunction

  // Address width for a buffer of the given depth; a depth of 1 still gets one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/trace_capture_mem.sv
// Simple dual-port sample buffer: synchronous write, synchronous read with 1-cycle latency.
module trace_capture_mem
  import trace_capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SW    = 16
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [ptr_w(DEPTH)-1:0] wr_addr_i,
  input  logic [SW-1:0]           wr_data_i,
  input  logic                    rd_en_i,
  input  logic [ptr_w(DEPTH)-1:0] rd_addr_i,
  output logic [SW-1:0]           rd_data_o
);

  logic [SW-1:0] mem_q [DEPTH];
  logic [SW-1:0] rd_data_q;

  // Write port plus registered read port; the read register holds its word while rd_en_i is low.
  // NOTE: storage and read register carry no reset; nothing reads them before they are written.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/trace_capture.sv
// Triggered capture of {y, x} into a DEPTH-entry buffer, drained over a valid/ready stream.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           x,
  input  logic [WIDTH-1:0]           y,
  input  logic                       arm,
  input  logic                       trigger,
  input  logic                       abort,
  output logic [sample_w(WIDTH)-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ptr_w(DEPTH):0]      count,
  output logic                       busy,
  output logic                       done
);

  localparam int SW = sample_w(WIDTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          rd_vld_q;     // RAM read register holds a word not yet moved to the output
  logic          out_valid_q;
  logic [SW-1:0] out_data_q;
  logic          busy_q;
  logic          done_q;

  logic          wr_en;
  logic          rd_en;
  logic          xfer;
  logic          load_out;
  logic          cap_last;
  logic [CW-1:0] in_flight;
  logic [SW-1:0] rd_data;

  // Handshake, RAM strobes and read scheduling; the RAM read register acts as the prefetch stage.
  // NOTE: every signal gets a default first so no latch can be inferred.
  always_comb begin
    in_flight = CW'(out_valid_q) + CW'(rd_vld_q);
    xfer      = out_valid_q && out_ready;
    load_out  = rd_vld_q && (!out_valid_q || out_ready);
    cap_last  = (state_q == ST_CAPTURE) && (count_q == DEPTH_C - 1'b1);
    wr_en     = !abort && (((state_q == ST_ARMED) && trigger) || (state_q == ST_CAPTURE));
    // Fetch word 0 on the DRAIN entry edge, then refill whenever the prefetch stage frees up.
    rd_en     = !abort && (cap_last ||
                ((state_q == ST_DRAIN) && (count_q > in_flight) && (!rd_vld_q || load_out)));
  end

  trace_capture_mem #(.DEPTH(DEPTH), .SW(SW)) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({y, x}),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // Control FSM with pointers, count, output register and registered status flags.
  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;

      if (rd_en)         rd_vld_q <= 1'b1;
      else if (load_out) rd_vld_q <= 1'b0;

      if (load_out) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rd_data;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q <= ST_ARMED;
            busy_q  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (trigger) begin
            count_q <= CW'(1);
            state_q <= (DEPTH == 1) ? ST_DRAIN : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          count_q <= count_q + 1'b1;
          if (cap_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (xfer) begin
            count_q <= count_q - 1'b1;
            if (count_q == CW'(1)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: control-vector table plus scoreboarded capture/drain runs.
module tb_trace_capture;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int SW    = 2 * WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] x, y;
  logic             arm, trigger, abort, out_ready;
  logic [SW-1:0]    out_data;
  logic             out_valid;
  logic [CW-1:0]    count;
  logic             busy, done;

  always #5 clk = ~clk;

  trace_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .arm       (arm),
    .trigger   (trigger),
    .abort     (abort),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  int            n_vec  = 0;
  int            n_miss = 0;
  logic [SW-1:0] sb_q [$];

  typedef struct {
    logic          arm;
    logic          trigger;
    logic          abort;
    logic          exp_busy;
    logic [CW-1:0] exp_count;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Arm, trigger and feed DEPTH samples; expected words go to the scoreboard as they are driven.
  // mode 0: constant FE/7F, 1: ramp with y=~x, 2: random. Ends at the negedge after DRAIN entry.
  task automatic capture(input int mode, input logic arm_mid);
    logic [WIDTH-1:0] xv, yv;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      case (mode)
        0:       begin xv = 8'hFE;            yv = 8'h7F; end
        1:       begin xv = WIDTH'(k);        yv = ~WIDTH'(k); end
        default: begin xv = WIDTH'($urandom); yv = WIDTH'($urandom); end
      endcase
      x       = xv;
      y       = yv;
      trigger = (k == 0);
      arm     = arm_mid && (k == 4);
      sb_q.push_back({yv, xv});
      step();
    end
    trigger = 1'b0;
    arm     = 1'b0;
  endtask

  // Drain with ready pattern 0 (always high) or 1 (1,0,0,1 repeating); stop_after < 0 means full drain.
  task automatic drain(input int pat, input logic trig_noise, input int stop_after);
    int            cnt_exp     = DEPTH;
    int            cyc         = 0;
    int            xfers       = 0;
    int            first_valid = -1;
    logic          stalled     = 1'b0;
    logic [SW-1:0] held        = '0;
    check("entry_valid", 32'(out_valid), 32'd0);
    check("entry_count", 32'(count), 32'(DEPTH));
    while (sb_q.size() > 0 && cyc < 200 && xfers != stop_after) begin
      out_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      trigger   = trig_noise ? 1'(cyc) : 1'b0;
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'(out_data), 32'(held));
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) begin
        check("word", 32'(out_data), 32'(sb_q.pop_front()));
        cnt_exp--;
        xfers++;
      end
      step();
      cyc++;
      check("drain_count", 32'(count), 32'(cnt_exp));
      if (sb_q.size() > 0) check("done_early", 32'(done), 32'd0);
    end
    trigger   = 1'b0;
    out_ready = 1'b0;
    check("first_valid_latency", 32'(first_valid), 32'd1);
    if (xfers == stop_after) return;
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    if (pat == 0) check("throughput_cycles", 32'(cyc), 32'(DEPTH + 1));
    check("done_pulse", 32'(done), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("count_after", 32'(count), 32'd0);
    step();
    check("done_width", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {arm, trigger, abort, exp_busy, exp_count} applied one per cycle from IDLE.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, CW'(0)};  // trigger ignored in IDLE
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, CW'(0)};  // arm -> ARMED
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, CW'(0)};  // arm again, still waiting
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, CW'(1)};  // trigger writes first sample
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, CW'(2)};  // arm ignored in CAPTURE
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, CW'(3)};  // trigger ignored in CAPTURE
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, CW'(4)};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, CW'(5)};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, CW'(0)};  // abort wins over arm/trigger
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, CW'(0)};  // trigger ignored back in IDLE

    rst = 1'b1; x = '0; y = '0; arm = 1'b0; trigger = 1'b0; abort = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    for (int i = 0; i < 10; i++) begin
      arm = vecs[i].arm; trigger = vecs[i].trigger; abort = vecs[i].abort;
      x = WIDTH'(i); y = WIDTH'(i + 100);
      step();
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_done", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd0);
    end
    arm = 1'b0; trigger = 1'b0; abort = 1'b0;
    step();

    // Ramp after abort must start at address 0; arm pulsed mid-capture must not disturb it.
    capture(1, 1'b1);
    drain(0, 1'b0, -1);

    // Basic constant run at full throughput.
    capture(0, 1'b0);
    drain(0, 1'b0, -1);

    // Backpressure with trigger toggling during drain.
    capture(2, 1'b0);
    drain(1, 1'b1, -1);

    // Asynchronous reset after three transfers, mid-cycle.
    capture(2, 1'b0);
    drain(0, 1'b0, 3);
    #2 rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_count", 32'(count), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    step();

    // A normal run after the mid-drain reset.
    capture(1, 1'b0);
    drain(0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
# trace_capture

Cycle-accurate capture block for the formal/BMC flow. It records the two 8-bit probe buses that the generated stimulus benches drive (`x`, `y`) into a small on-chip buffer, starting from a trigger. It then drains the captured words through a valid/ready stream so a host or checker can read back what the DUT saw. It is the reading end of the per-cycle stimulus the trace benches write, and sits beside the timer DUT in the same `top`.

## Interface
Parameters:
- `DEPTH`, 16: number of samples captured per run; power of two, 2..256.
- `WIDTH`, 8: width of each probe bus.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `x`  in  WIDTH  probe bus A, sampled every capture cycle.
- `y`  in  WIDTH  probe bus B, sampled every capture cycle.
- `arm`  in  1  start a run; honoured only in IDLE.
- `trigger`  in  1  begin capture; honoured only in ARMED.
- `abort`  in  1  synchronous return to IDLE from any state; discards the buffer.
- `out_data`  out  2*WIDTH  drained sample, `{y, x}`.
- `out_valid`  out  1  `out_data` holds an undelivered sample.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `count`  out  clog2(DEPTH)+1  samples stored and not yet drained.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse on the cycle after the last sample transfers.

## Operation
- FSM states: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE:
  - `arm`=1 moves to ARMED.
  - `trigger` is ignored.
- ARMED:
  - `trigger`=1 writes `{y,x}` of that same cycle to address 0 and sets count=1.
  - If DEPTH==1, go directly to DRAIN; otherwise go to CAPTURE.
- CAPTURE:
  - Writes `{y,x}` every cycle at the write pointer and increments count.
  - `trigger` and `arm` are ignored.
  - After the write with count reaching DEPTH, go to DRAIN.
- DRAIN:
  - Read pointer starts at 0.
  - A transfer happens when `out_valid && out_ready`; each transfer decrements count and advances the read pointer.
  - After the transfer of sample DEPTH-1, go to IDLE and pulse `done`.
- Ordering: samples come out in capture order. The word at read index k equals the probes k cycles after the trigger cycle.
- `out_data` is held stable while `out_valid` is high and `out_ready` is low.
- `out_valid` never drops without a transfer, except on `abort` or `rst`.
- `abort` has priority over every other input. Next state is IDLE, count=0, `out_valid`=0, no `done`.
- Pointers are clog2(DEPTH) bits and wrap naturally; count never exceeds DEPTH.

## Timing
- Reset values: state IDLE, `out_data`=0, `out_valid`=0, `count`=0, `busy`=0, `done`=0, both pointers 0.
- A trigger sampled at edge N stores the probes present before edge N; a run of DEPTH samples is edges N..N+DEPTH-1.
- The DRAIN entry edge issues the first RAM read. `out_valid` rises one cycle later, so first-word latency is 1 cycle after entering DRAIN.
- Full throughput: with `out_ready` held high, DEPTH words transfer on DEPTH consecutive cycles. This needs a one-entry prefetch/skid register in front of `out_data`.
- `done` rises on the cycle after the final transfer; `busy` falls on that same cycle.
- `rst` asserted mid-run clears everything asynchronously. The first cycle after deassertion behaves as IDLE.

## Structure
- The shared package holds:
  - the state enum (IDLE/ARMED/CAPTURE/DRAIN);
  - a `SAMPLE_W = 2*WIDTH` helper;
  - the pointer-width function, so the host-side checker reuses it.
- Sub-module `trace_mem`: simple dual-port RAM, DEPTH x SAMPLE_W, one synchronous write port, one synchronous read port with 1-cycle latency, no reset on contents.
- The top level contains the FSM, pointers, count and the output skid register.

## Test plan
- Basic run: arm, then trigger with x=8'hFE, y=8'h7F held for 16 cycles, `out_ready`=1. Expect 16 words of 16'h7FFE on consecutive cycles, then `done` for 1 cycle and count=0.
- Ramp ordering: trigger while x counts 0..15 per cycle and y=~x. Word k must equal `{~k, k}`; the first `out_valid` comes 1 cycle after DRAIN entry.
- Backpressure: toggle `out_ready` 1,0,0,1 during drain. `out_data` must be stable while stalled, with no duplicated or dropped words. count must step 16→0 by exactly one per transfer.
- Ignored inputs:
  - `trigger` in IDLE leaves state IDLE;
  - `arm` during CAPTURE leaves the write pointer unchanged;
  - `trigger` during DRAIN does not disturb the output.
- Abort: abort in CAPTURE with count=5 gives IDLE, count=0, no `done`. A fresh arm/trigger then captures from address 0.
- Reset mid-drain: assert `rst` asynchronously after 3 transfers. Immediately `out_valid`=0, count=0, `busy`=0, and a subsequent run completes normally.
